demux_dispatch_sched: RTL and testbench

//  Sequencing controller for the 1-to-4 demux datapath. Takes one valid/ready input

---
 rtl/demux_sched_pkg.sv | 28 ++
 rtl/demux_onehot_1x4.sv | 21 ++
 rtl/demux_dispatch_sched.sv | 116 +++++++++++
 tb/tb_demux_dispatch_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the 1-to-4 demux dispatch scheduler.
// The round-robin pick searches forward from the last granted channel.
package demux_sched_pkg;

   localparam int NCH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic MODE_DEST = 1'b0;
   localparam logic MODE_RR   = 1'b1;

   // Walk ptr+4 down to ptr+1 so the nearest ready channel is the one kept.
   function automatic logic [1:0] rr_pick_f(input logic [1:0] ptr,
                                            input logic [NCH-1:0] rdy);
      logic [1:0] pick;
      logic [1:0] cand;
      pick = ptr + 2'd1;
      for (int i = NCH; i >= 1; i--) begin
         cand = ptr + 2'(i);
         if (rdy[cand]) pick = cand;
      end
      return pick;
   endfunction

endpackage

// File: rtl/demux_onehot_1x4.sv
// One-hot channel valid decode, built as a two-level tree of 1x2 demuxes
// so it matches the structure of the existing demux datapath.
module demux_onehot_1x4
   import demux_sched_pkg::*;
(
   input  logic           valid_i,
   input  logic [1:0]     sel_i,
   output logic [NCH-1:0] out_valid_o
);

   logic [1:0] lvl1;

   assign lvl1[0] = valid_i & ~sel_i[1];
   assign lvl1[1] = valid_i &  sel_i[1];

   assign out_valid_o[0] = lvl1[0] & ~sel_i[0];
   assign out_valid_o[1] = lvl1[0] &  sel_i[0];
   assign out_valid_o[2] = lvl1[1] & ~sel_i[0];
   assign out_valid_o[3] = lvl1[1] &  sel_i[0];

endmodule

// File: rtl/demux_dispatch_sched.sv
// Sequencing controller for the 1-to-4 demux: one-word buffer, tag or round-robin
// channel choice, and timeout drop of a word whose channel stalls too long.
module demux_dispatch_sched
   import demux_sched_pkg::*;
#(
   parameter int DW      = 8,
   parameter int TIMEOUT = 16,
   parameter int CW      = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mode,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [DW-1:0]  in_data,
   input  logic [1:0]     in_dest,
   output logic [NCH-1:0] out_valid,
   input  logic [NCH-1:0] out_ready,
   output logic [DW-1:0]  out_data,
   output logic           drop,
   output logic [CW-1:0]  drop_cnt
);

   localparam int            SW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
   localparam bit            TO_EN      = (TIMEOUT != 0);

   state_t        state_q, state_d;
   logic [DW-1:0] buf_q, buf_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    rr_ptr_q, rr_ptr_d;
   logic [SW-1:0] stall_q, stall_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;

   logic       hold;
   logic       fire;
   logic       timeout_hit;
   logic       accept;
   logic [1:0] rr_pick;

   assign hold        = (state_q == HOLD);
   assign fire        = hold & out_ready[sel_q];
   assign timeout_hit = TO_EN && hold && !fire && (stall_q == STALL_LAST);
   assign accept      = in_valid & in_ready;
   assign rr_pick     = rr_pick_f(rr_ptr_q, out_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = HOLD;
         HOLD: begin
            if (accept)                   state_d = HOLD;
            else if (fire || timeout_hit) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // in_ready is also held low during reset so nothing is taken while rst=1.
   always_comb begin
      in_ready = !rst && (!hold || fire);
      drop     = timeout_hit;
   end

   demux_onehot_1x4 u_onehot (
      .valid_i     (hold),
      .sel_i       (sel_q),
      .out_valid_o (out_valid)
   );

   assign out_data = buf_q;
   assign drop_cnt = drop_cnt_q;

   always_comb begin
      buf_d      = buf_q;
      sel_d      = sel_q;
      rr_ptr_d   = rr_ptr_q;
      stall_d    = stall_q;
      drop_cnt_d = drop_cnt_q;
      if (accept) begin
         buf_d = in_data;
         if (mode == MODE_RR) begin
            sel_d    = rr_pick;
            rr_ptr_d = rr_pick;
         end else begin
            sel_d = in_dest;
         end
      end
      if (accept || fire || !hold || timeout_hit) stall_d = '0;
      else if (TO_EN)                             stall_d = stall_q + 1'b1;
      if (timeout_hit && (drop_cnt_q != {CW{1'b1}}))
         drop_cnt_d = drop_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q      <= '0;
         sel_q      <= '0;
         rr_ptr_q   <= 2'd3;
         stall_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         buf_q      <= buf_d;
         sel_q      <= sel_d;
         rr_ptr_q   <= rr_ptr_d;
         stall_q    <= stall_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule

// File: tb/tb_demux_dispatch_sched.sv
// Bench for demux_dispatch_sched: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the dispatch rules.
module tb_demux_dispatch_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic [1:0] in_dest = 2'd0;
   logic [3:0] out_valid;
   logic [3:0] out_ready = 4'b0000;
   logic [7:0] out_data;
   logic       drop;
   logic [7:0] drop_cnt;

   logic       rst2 = 1'b1;
   logic       in_valid2 = 1'b0;
   logic       in_ready2;
   logic [3:0] out_valid2;
   logic [3:0] out_ready2 = 4'b0000;
   logic [7:0] out_data2;
   logic       drop2;
   logic [1:0] drop_cnt2;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   demux_dispatch_sched #(.DW(8), .TIMEOUT(16), .CW(8)) dut (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_dest(in_dest), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .drop(drop), .drop_cnt(drop_cnt)
   );

   demux_dispatch_sched #(.DW(8), .TIMEOUT(4), .CW(2)) dut2 (
      .clk(clk), .rst(rst2), .mode(mode), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_data(in_data), .in_dest(in_dest), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_data(out_data2), .drop(drop2), .drop_cnt(drop_cnt2)
   );

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      in_valid = 1'b1;
      #2;
      n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
      n_cmp++; if (drop !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %b/%0d expected 0/0", drop, drop_cnt); end
      in_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_dest();
      do_reset();
      mode = 1'b0; in_dest = 2'd2; in_data = 8'hA5; out_ready = 4'b1111; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL dest_out_valid: got %b expected 0100", out_valid); end
      n_cmp++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL dest_out_data: got %h expected a5", out_data); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dest_in_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 4'b0000 || out_data !== 8'hA5) begin n_fail++; $display("FAIL dest_idle: got %b/%h expected 0000/a5", out_valid, out_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_rr_back_to_back();
      logic [3:0] exp_ov;
      do_reset();
      mode = 1'b1; out_ready = 4'b1111;
      for (int i = 0; i <= 8; i++) begin
         in_valid = (i < 8);
         in_data  = 8'(8'h10 + i);
         @(negedge clk);
         if (i < 8) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rr_b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
         end
         if (i > 0) begin
            exp_ov = 4'b0001 << ((i - 1) % 4);
            n_cmp++; if (out_valid !== exp_ov || out_data !== 8'(8'h10 + i - 1)) begin
               n_fail++; $display("FAIL rr_b2b_word[%0d]: got %b/%h expected %b/%h", i - 1, out_valid, out_data, exp_ov, 8'(8'h10 + i - 1));
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_rr_single_ready();
      logic [3:0] exp_ov;
      do_reset();
      mode = 1'b1;
      for (int i = 0; i <= 7; i++) begin
         out_ready = (i < 6) ? 4'b1000 : 4'b1111;
         in_valid  = (i < 7);
         in_data   = 8'(8'h40 + i);
         @(negedge clk);
         if (i > 0) begin
            exp_ov = (i - 1 < 6) ? 4'b1000 : 4'b0001;
            n_cmp++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL rr_single_word[%0d]: got %b expected %b", i - 1, out_valid, exp_ov); end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      mode = 1'b0; in_dest = 2'd1; in_data = 8'h77; out_ready = 4'b1101; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c < 16) begin
            n_cmp++; if (drop !== 1'b0 || out_valid !== 4'b0010) begin n_fail++; $display("FAIL timeout_hold[%0d]: got drop=%b ov=%b expected 0/0010", c, drop, out_valid); end
         end else begin
            n_cmp++; if (drop !== 1'b1) begin n_fail++; $display("FAIL timeout_drop_pulse: got %b expected 1", drop); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL timeout_in_ready: got %b expected 0", in_ready); end
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_cmp++; if (out_valid !== 4'b0000 || drop !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got ov=%b drop=%b expected 0000/0", out_valid, drop); end
      n_cmp++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL timeout_drop_cnt: got %0d expected 1", drop_cnt); end
      @(posedge clk); #1;
      in_data = 8'h88; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         if (c == 16) out_ready = 4'b1111;
         @(negedge clk);
         if (c == 16) begin
            n_cmp++; if (drop !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_late_fire: got drop=%b ir=%b expected 0/1", drop, in_ready); end
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_cmp++; if (drop_cnt !== 8'd1 || out_valid !== 4'b0000 || out_data !== 8'h88) begin
         n_fail++; $display("FAIL timeout_late_fire_after: got cnt=%0d ov=%b d=%h expected 1/0000/88", drop_cnt, out_valid, out_data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      mode = 1'b0; in_dest = 2'd2; in_data = 8'h3C; out_ready = 4'b0000; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      #2;
      n_cmp++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL async_pre_hold: got %b expected 0100", out_valid); end
      rst = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 4'b0000 || in_ready !== 1'b0) begin n_fail++; $display("FAIL async_immediate: got ov=%b ir=%b expected 0000/0", out_valid, in_ready); end
      @(posedge clk); #3 rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 4'b0000 || in_ready !== 1'b1 || drop_cnt !== 8'd0) begin
         n_fail++; $display("FAIL async_after_release: got ov=%b ir=%b cnt=%0d expected 0000/1/0", out_valid, in_ready, drop_cnt);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_saturation();
      int pulses;
      bit seen;
      pulses = 0;
      @(posedge clk); #1 rst2 = 1'b0;
      mode = 1'b0; in_dest = 2'd0; out_ready2 = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         in_data = 8'(k); in_valid2 = 1'b1;
         @(posedge clk); #1 in_valid2 = 1'b0;
         seen = 1'b0;
         for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (drop2 === 1'b1) begin pulses++; seen = 1'b1; end
            @(posedge clk); #1;
         end
         n_cmp++; if (drop_cnt2 !== 2'((k + 1 > 3) ? 3 : k + 1)) begin
            n_fail++; $display("FAIL sat_drop_cnt[%0d]: got %0d expected %0d", k, drop_cnt2, (k + 1 > 3) ? 3 : k + 1);
         end
      end
      n_cmp++; if (pulses != 5) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 5", pulses); end
   endtask

   task automatic test_random();
      bit         m_full;
      int         m_ch, m_stall, m_ptr, m_drops, pick, phase;
      logic [7:0] m_data;
      logic [3:0] mask, e_ov;
      bit         e_fire, e_ir, e_drop, found;
      do_reset();
      m_full = 0; m_ch = 0; m_stall = 0; m_ptr = 3; m_drops = 0; m_data = 8'h00;
      phase = 0; mask = 4'b0000;
      for (int cyc = 0; cyc < 1200; cyc++) begin
         if (cyc % 40 == 0) begin
            phase = $urandom_range(0, 2);
            mask  = 4'($urandom);
         end
         in_valid  = ($urandom_range(0, 9) < 7);
         mode      = 1'($urandom);
         in_dest   = 2'($urandom);
         in_data   = 8'($urandom);
         out_ready = (phase == 0) ? 4'($urandom) : (phase == 1) ? mask : 4'b1111;
         @(negedge clk);
         e_fire = m_full && out_ready[m_ch];
         e_ir   = !m_full || e_fire;
         e_drop = m_full && !e_fire && (m_stall == 15);
         e_ov   = m_full ? 4'(1 << m_ch) : 4'b0000;
         n_cmp++; if (out_valid !== e_ov) begin n_fail++; $display("FAIL rand_out_valid@%0d: got %b expected %b", cyc, out_valid, e_ov); end
         n_cmp++; if (out_data !== m_data) begin n_fail++; $display("FAIL rand_out_data@%0d: got %h expected %h", cyc, out_data, m_data); end
         n_cmp++; if (in_ready !== e_ir) begin n_fail++; $display("FAIL rand_in_ready@%0d: got %b expected %b", cyc, in_ready, e_ir); end
         n_cmp++; if (drop !== e_drop) begin n_fail++; $display("FAIL rand_drop@%0d: got %b expected %b", cyc, drop, e_drop); end
         n_cmp++; if (drop_cnt !== 8'(m_drops)) begin n_fail++; $display("FAIL rand_drop_cnt@%0d: got %0d expected %0d", cyc, drop_cnt, m_drops); end
         if (in_valid && e_ir) begin
            if (mode) begin
               pick = (m_ptr + 1) % 4;
               found = 0;
               for (int s = 1; s <= 4; s++) begin
                  if (!found && out_ready[(m_ptr + s) % 4]) begin pick = (m_ptr + s) % 4; found = 1; end
               end
               m_ptr = pick;
            end else begin
               pick = int'(in_dest);
            end
            m_ch = pick; m_full = 1; m_data = in_data; m_stall = 0;
         end else if (e_fire) begin
            m_full = 0; m_stall = 0;
         end else if (e_drop) begin
            m_full = 0; m_stall = 0;
            if (m_drops < 255) m_drops++;
         end else if (m_full) begin
            m_stall++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      do_reset();
      test_reset();
      test_dest();
      test_rr_back_to_back();
      test_rr_single_ready();
      test_timeout();
      test_async_reset();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
